chacha_inv_permute: RTL and testbench
=====================================

# chacha_inv_permute

Iterative inverse ChaCha20 block permutation. It accepts a 16-word permuted state over a word-serial valid/ready stream and undoes DOUBLE_ROUNDS ChaCha double rounds, one inverse half-round per cycle. It returns the recovered 16-word input state over a matching word-serial stream. It is the reverse-direction counterpart of the ChaCha quarter-round datapath and is used for keystream-state recovery and for round-trip self-check of the forward core.

## Interface
- DOUBLE_ROUNDS, 10, number of double rounds to invert; legal range 1..15.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data holds a state word.
- in_ready  output  1  block accepts a word this cycle.
- in_data  input  32  state word; words arrive in index order 0..15.
- out_valid  output  1  out_data holds a recovered word.
- out_ready  input  1  sink accepts a word this cycle.
- out_data  output  32  recovered word; words leave in index order 0..15.
- busy  output  1  high in RUN state.

## Operation
- State: 16 x 32-bit registers s[0..15], 4-bit word index widx, 5-bit half-round counter hcnt, FSM {LOAD, RUN, DRAIN}.
- LOAD: in_ready=1. Each in_valid&in_ready writes s[widx] and increments widx. When the word at widx=15 is accepted, widx wraps to 0, hcnt is set to 0, and the FSM enters RUN.
- RUN: in_ready=0, out_valid=0, busy=1. Each cycle applies one inverse half-round to s and increments hcnt.
  - Even hcnt: inverse diagonal round, groups (0,5,10,15) (1,6,11,12) (2,7,8,13) (3,4,9,14).
  - Odd hcnt: inverse column round, groups (0,4,8,12) (1,5,9,13) (2,6,10,14) (3,7,11,15).
  - After hcnt = 2*DOUBLE_ROUNDS-1 is applied, the FSM enters DRAIN.
- Inverse quarter round on group (a,b,c,d), evaluated sequentially with each line using the updated values. All arithmetic is mod 2^32 and ror is rotate right.
  - b = ror(b,7) ^ c; c = c - d
  - d = ror(d,8) ^ a; a = a - b
  - b = ror(b,12) ^ c; c = c - d
  - d = ror(d,16) ^ a; a = a - b
- The four groups of a half-round are disjoint and computed in parallel within the cycle.
- No feed-forward addition is performed; the output is the pure inverse permutation, so the forward permutation followed by this block is the identity.
- DRAIN: out_valid=1, out_data=s[widx]. Each out_valid&out_ready increments widx. After word 15 is accepted, widx wraps to 0 and the FSM returns to LOAD.
- in_valid outside LOAD is ignored; data is not captured.
- Reset (asynchronous, any state, including mid-RUN or mid-DRAIN): FSM=LOAD, widx=0, hcnt=0, all s=0. Any partially loaded or partially drained block is discarded with no output.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, busy=0.
- in_ready, out_valid, busy and out_data are decoded from registered state only; there are no combinational paths from in_valid or out_ready.
- Load: one word per cycle at full throughput.
- Latency: if word 15 is accepted in cycle T, RUN occupies T+1..T+2*DOUBLE_ROUNDS, and out_valid first rises in cycle T+2*DOUBLE_ROUNDS+1 (T+21 at the default).
- Drain: one word per cycle when out_ready=1. While out_ready=0, out_data and out_valid hold stable.
- in_ready rises in the cycle after word 15 is drained. Block throughput is 16+2*DOUBLE_ROUNDS+16 cycles per block with no overlap.

## Test plan
- All-zero state loaded (16 x 0x00000000) -> out_valid at T+21, 16 outputs all 0x00000000.
- Round-trip: X[i]=0x00000000+i for i=0..15. Bench forward model applies 10 double rounds to X; feed the result -> outputs equal 0x00000000..0x0000000F in order. Repeat with 100 random states, plus DOUBLE_ROUNDS=1 and DOUBLE_ROUNDS=4 builds.
- Latency/handshake: with in_valid gapped (1 word every 3 cycles), in_ready stays 1 throughout LOAD. in_ready=0 and busy=1 for exactly 20 cycles after word 15; in_valid pulses during RUN cause no state change.
- Backpressure: out_ready low for 5 cycles at word 7 -> out_data stable at word 7 value, out_valid stays 1. Sequence resumes with no skipped or duplicated words.
- Reset mid-RUN (rst_n low at hcnt=9) -> outputs at reset values immediately. Next full load gives correct round-trip results and no stale output.
- Back-to-back blocks: second block's word 0 is offered in the cycle in_ready rises -> it is accepted that cycle, and both blocks' outputs are correct.

Source files
------------

// File: rtl/chacha_inv_permute_if.sv
// Word-serial stream bundle for the inverse ChaCha permutation: one 32-bit
// input stream (state words in) and one 32-bit output stream (words out).
interface chacha_inv_permute_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    // Source of input words and sink of recovered words.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    // The permutation block itself.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/chacha_inv_permute.sv
// Iterative inverse ChaCha20 block permutation. Loads 16 words, undoes
// DOUBLE_ROUNDS double rounds at one inverse half-round per cycle (diagonal
// first, then column, mirroring the forward order), then drains 16 words.
module chacha_inv_permute #(
    parameter int DOUBLE_ROUNDS = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    chacha_inv_permute_if.slave    io,
    output logic                   busy
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
    } qr_t;

    localparam logic [4:0] LAST_H = 5'(2 * DOUBLE_ROUNDS - 1);

    state_t      state_q, state_d;
    logic [3:0]  widx_q, widx_d;
    logic [4:0]  hcnt_q, hcnt_d;
    logic [31:0] s_q   [16];
    logic [31:0] s_d   [16];
    logic [31:0] s_rnd [16];
    logic [1:0]  diag_sh;

    function automatic logic [31:0] ror(input logic [31:0] w, input int n);
        return (w >> n) | (w << (32 - n));
    endfunction

    // Undo one forward quarter round; each line consumes the previous updates.
    function automatic qr_t inv_qr(input qr_t x);
        qr_t y;
        y   = x;
        y.b = ror(y.b, 7) ^ y.c;
        y.c = y.c - y.d;
        y.d = ror(y.d, 8) ^ y.a;
        y.a = y.a - y.b;
        y.b = ror(y.b, 12) ^ y.c;
        y.c = y.c - y.d;
        y.d = ror(y.d, 16) ^ y.a;
        y.a = y.a - y.b;
        return y;
    endfunction

    // Even half-rounds are diagonal (row r shifted by r), odd ones are columns.
    assign diag_sh = hcnt_q[0] ? 2'd0 : 2'd1;

    // One inverse half-round: four disjoint quarter rounds in parallel.
    always_comb begin
        s_rnd = s_q;
        for (int k = 0; k < 4; k++) begin
            qr_t g;
            g = inv_qr({s_q[k],
                        s_q[{2'b01, 2'(k) + diag_sh}],
                        s_q[{2'b10, 2'(k) + 2'(diag_sh * 2'd2)}],
                        s_q[{2'b11, 2'(k) + 2'(diag_sh * 2'd3)}]});
            s_rnd[k]                                = g.a;
            s_rnd[{2'b01, 2'(k) + diag_sh}]         = g.b;
            s_rnd[{2'b10, 2'(k) + 2'(diag_sh * 2'd2)}] = g.c;
            s_rnd[{2'b11, 2'(k) + 2'(diag_sh * 2'd3)}] = g.d;
        end
    end

    // Next-state logic for the LOAD -> RUN -> DRAIN sequence.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves
        // a signal unassigned, which would otherwise infer a latch.
        state_d = state_q;
        widx_d  = widx_q;
        hcnt_d  = hcnt_q;
        s_d     = s_q;
        case (state_q)
            LOAD: begin
                if (io.in_valid) begin
                    s_d[widx_q] = io.in_data;
                    widx_d      = widx_q + 4'd1;
                    if (widx_q == 4'd15) begin
                        hcnt_d  = 5'd0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                s_d    = s_rnd;
                hcnt_d = hcnt_q + 5'd1;
                if (hcnt_q == LAST_H) state_d = DRAIN;
            end
            DRAIN: begin
                if (io.out_ready) begin
                    widx_d = widx_q + 4'd1;
                    if (widx_q == 4'd15) state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // State registers; reset discards any partial block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
            widx_q  <= 4'd0;
            hcnt_q  <= 5'd0;
            // NOTE: the word array is cleared on reset so a discarded block can
            // never reappear on out_data; it is small enough to be plain flops.
            for (int i = 0; i < 16; i++) s_q[i] <= 32'd0;
        end else begin
            // NOTE: non-blocking assignments here so all registers update from
            // the same pre-edge values.
            state_q <= state_d;
            widx_q  <= widx_d;
            hcnt_q  <= hcnt_d;
            s_q     <= s_d;
        end
    end

    // Outputs decode registered state only.
    assign io.in_ready  = (state_q == LOAD);
    assign io.out_valid = (state_q == DRAIN);
    assign io.out_data  = (state_q == DRAIN) ? s_q[widx_q] : 32'd0;
    assign busy         = (state_q == RUN);

endmodule

// File: tb/tb_chacha_inv_permute.sv
// Directed bench for chacha_inv_permute: reset values, latency, gapped load,
// RUN-time input pulses, backpressure, mid-RUN reset and back-to-back blocks.
// Expected words come from a forward ChaCha permutation model in the bench.
module tb_chacha_inv_permute;

    localparam int DR = 10;

    typedef logic [31:0] blk_t [16];

    logic clk = 1'b0;
    logic rst_n;
    logic busy;
    int   errors = 0;
    int   checks = 0;

    chacha_inv_permute_if io ();

    chacha_inv_permute #(.DOUBLE_ROUNDS(DR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rol(input logic [31:0] w, input int n);
        return (w << n) | (w >> (32 - n));
    endfunction

    // Forward quarter round on words (a,b,c,d) of s.
    function automatic blk_t fqr(input blk_t s, input int a, input int b,
                                 input int c, input int d);
        blk_t t;
        t = s;
        t[a] = t[a] + t[b]; t[d] = rol(t[d] ^ t[a], 16);
        t[c] = t[c] + t[d]; t[b] = rol(t[b] ^ t[c], 12);
        t[a] = t[a] + t[b]; t[d] = rol(t[d] ^ t[a], 8);
        t[c] = t[c] + t[d]; t[b] = rol(t[b] ^ t[c], 7);
        return t;
    endfunction

    function automatic blk_t fwd_perm(input blk_t x, input int dr);
        blk_t s;
        s = x;
        for (int r = 0; r < dr; r++) begin
            s = fqr(s, 0, 4, 8, 12);  s = fqr(s, 1, 5, 9, 13);
            s = fqr(s, 2, 6, 10, 14); s = fqr(s, 3, 7, 11, 15);
            s = fqr(s, 0, 5, 10, 15); s = fqr(s, 1, 6, 11, 12);
            s = fqr(s, 2, 7, 8, 13);  s = fqr(s, 3, 4, 9, 14);
        end
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Feed 16 words, gap idle cycles between words; in_ready must hold at 1.
    task automatic load_block(input blk_t w, input int gap);
        for (int i = 0; i < 16; i++) begin
            int t;
            io.in_valid = 1'b1;
            io.in_data  = w[i];
            t = 0;
            while (io.in_ready !== 1'b1 && t < 100) begin tick(); t++; end
            checks++;
            if (io.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL load_ready word %0d: in_ready=%b required 1", i, io.in_ready);
            end
            tick();
            io.in_valid = 1'b0;
            if (i < 15) begin
                for (int g = 0; g < gap; g++) begin
                    checks++;
                    if (io.in_ready !== 1'b1) begin
                        errors++;
                        $display("FAIL gap_ready word %0d: in_ready=%b required 1", i, io.in_ready);
                    end
                    tick();
                end
            end
        end
    endtask

    // Wait for out_valid; optionally check latency/busy and pulse in_valid during RUN.
    task automatic wait_out(input bit chk_lat, input bit pulse);
        int n;
        int nbusy;
        n = 0;
        nbusy = 0;
        while (io.out_valid !== 1'b1 && n < 200) begin
            if (busy === 1'b1 && io.in_ready === 1'b0) nbusy++;
            io.in_valid = pulse ? n[0] : 1'b0;
            io.in_data  = 32'hDEAD_BEEF;
            tick();
            n++;
        end
        io.in_valid = 1'b0;
        checks++;
        if (io.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL out_timeout: out_valid=%b required 1 after %0d cycles", io.out_valid, n);
        end
        if (chk_lat) begin
            checks++;
            if (n != 2 * DR) begin
                errors++;
                $display("FAIL latency: cycles=%0d required %0d", n, 2 * DR);
            end
            checks++;
            if (nbusy != 2 * DR) begin
                errors++;
                $display("FAIL busy_cycles: got %0d required %0d", nbusy, 2 * DR);
            end
        end
    endtask

    // Drain 16 words and compare; stall out_ready for 5 cycles at stall_at.
    task automatic drain_check(input blk_t exp, input int stall_at, input string name);
        for (int i = 0; i < 16; i++) begin
            if (i == stall_at) begin
                io.out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    tick();
                    checks++;
                    if (io.out_valid !== 1'b1 || io.out_data !== exp[i]) begin
                        errors++;
                        $display("FAIL %s stall word %0d: valid=%b data=%h required 1 %h",
                                 name, i, io.out_valid, io.out_data, exp[i]);
                    end
                end
                io.out_ready = 1'b1;
            end
            checks++;
            if (io.out_valid !== 1'b1 || io.out_data !== exp[i]) begin
                errors++;
                $display("FAIL %s word %0d: valid=%b data=%h required 1 %h",
                         name, i, io.out_valid, io.out_data, exp[i]);
            end
            tick();
        end
        checks++;
        if (io.in_ready !== 1'b1 || io.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s end: in_ready=%b out_valid=%b required 1 0",
                     name, io.in_ready, io.out_valid);
        end
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (io.in_ready !== 1'b1 || io.out_valid !== 1'b0 ||
            io.out_data !== 32'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: in_ready=%b out_valid=%b out_data=%h busy=%b required 1 0 00000000 0",
                     name, io.in_ready, io.out_valid, io.out_data, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        io.in_valid  = 1'b0;
        io.in_data   = 32'd0;
        io.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset_held");
        rst_n = 1'b1;
        tick();
        check_idle("reset_released");
    endtask

    task automatic test_zero();
        blk_t z;
        for (int i = 0; i < 16; i++) z[i] = 32'd0;
        load_block(z, 0);
        wait_out(1'b1, 1'b0);
        drain_check(z, -1, "zero");
    endtask

    task automatic test_roundtrip_gapped();
        blk_t x;
        for (int i = 0; i < 16; i++) x[i] = 32'(i);
        load_block(fwd_perm(x, DR), 2);
        wait_out(1'b1, 1'b1);
        drain_check(x, 7, "roundtrip_idx");
    endtask

    task automatic test_random();
        blk_t x;
        for (int n = 0; n < 100; n++) begin
            for (int i = 0; i < 16; i++) x[i] = $urandom;
            load_block(fwd_perm(x, DR), 0);
            wait_out(1'b0, 1'b0);
            drain_check(x, -1, "roundtrip_rand");
        end
    endtask

    task automatic test_reset_mid_run();
        blk_t x;
        for (int i = 0; i < 16; i++) x[i] = 32'hA5A5_0000 + 32'(i);
        load_block(fwd_perm(x, DR), 0);
        repeat (9) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("reset_mid_run");
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 25; k++) begin
            tick();
            checks++;
            if (io.out_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL stale_after_reset cycle %0d: out_valid=%b busy=%b required 0 0",
                         k, io.out_valid, busy);
            end
        end
        for (int i = 0; i < 16; i++) x[i] = 32'h0F0F_1234 ^ (32'(i) << 8);
        load_block(fwd_perm(x, DR), 0);
        wait_out(1'b1, 1'b0);
        drain_check(x, -1, "after_reset");
    endtask

    task automatic test_back_to_back();
        blk_t a;
        blk_t b;
        for (int i = 0; i < 16; i++) begin
            a[i] = 32'h1111_1111 * 32'(i + 1);
            b[i] = 32'hFFFF_FFFF - 32'(i);
        end
        load_block(fwd_perm(a, DR), 0);
        wait_out(1'b0, 1'b0);
        drain_check(a, -1, "b2b_first");
        // in_ready has just risen; word 0 of the next block is offered now.
        load_block(fwd_perm(b, DR), 0);
        wait_out(1'b1, 1'b0);
        drain_check(b, -1, "b2b_second");
    endtask

    initial begin
        test_reset();
        test_zero();
        test_roundtrip_gapped();
        test_random();
        test_reset_mid_run();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
